vdp_vram_sched: RTL and testbench
=================================

# vdp_vram_sched

VRAM slot scheduler for the VDP. Divides VRAM bandwidth into a repeating 8-slot one-hot ring, one slot per pxclk, aligned to tile boundaries. It grants each slot to either the display fetch engine (name/pattern/color/sprite reads) or a single buffered CPU access. It sits between `vdp_fsm`'s DMA fetch port, the CPU register interface and the single-port synchronous VRAM.

## Interface
- `VRAM_SIZE`, 8192, VRAM depth in bytes; `AW = $clog2(VRAM_SIZE)`
- `CPU_SLOTS`, 8'h04, one-hot mask of slots reserved for the CPU whenever fetching is enabled
- `pxclk` in 1: the block's one clock, pixel clock
- `reset` in 1: asynchronous, active-high
- `line_start` in 1: single-cycle pulse; realigns the ring so the next cycle is slot 8'h01
- `fetch_en` in 1: the display is fetching in this region; when low, every slot is CPU-eligible
- `disp_rd` in 1: the display requests a read in the current slot
- `disp_addr` in AW: display read address
- `slot` out 8: one-hot current slot
- `disp_data` out 8, `disp_valid` out 1: display read data, with a one-cycle valid strobe
- `cpu_req` in 1, `cpu_we` in 1, `cpu_addr` in AW, `cpu_wdata` in 8: CPU access request
- `cpu_busy` out 1, `cpu_done` out 1, `cpu_rdata` out 8: CPU handshake and read data
- `vram_addr` out AW, `vram_rd` out 1, `vram_we` out 1, `vram_din` out 8, `vram_dout` in 8: RAM port; read data is valid the cycle after `vram_rd`

## Operation
- **Ring:**
  - Resets to 8'h01 and rotates left every cycle, wrapping 8'h80→8'h01.
  - `line_start` forces 8'h01 on the next cycle regardless of the current value.
- **Slot owner, evaluated each cycle:**
  - Display owns the slot iff `fetch_en` & `disp_rd` & !(slot & `CPU_SLOTS`).
  - Otherwise the CPU may issue, if its buffer is pending.
  - `disp_rd` asserted in a CPU-reserved slot is ignored: no read, no `disp_valid`.
- **Display read:** `vram_addr`=`disp_addr` and `vram_rd`=1 combinationally in the owning cycle. `disp_data`=`vram_dout` and `disp_valid`=1 on the following cycle.
- **CPU buffer states:**
  - IDLE: `cpu_req` while !`cpu_busy` latches we/addr/wdata and moves to PEND.
  - PEND: waits for the first eligible cycle, then drives the RAM port (`vram_we` for a write, `vram_rd` for a read) and moves to DONE.
  - DONE: one cycle long. `cpu_done`=1; on a read, `cpu_rdata`←`vram_dout`. Returns to IDLE.
- **`cpu_busy`:** 1 in PEND, 0 in IDLE and in DONE. A new request may therefore be accepted during the DONE cycle.
- **Precedence:** the display always wins a non-CPU slot it requests. The CPU never preempts the display.
- **Idle port:** when no access is issued, `vram_rd`=`vram_we`=0 and `vram_addr`=0.
- **Reset mid-operation:** the buffer is discarded; no `cpu_done` is produced for the discarded access.

## Timing
- **Reset values:**
  - `slot`=8'h01.
  - `cpu_busy`, `cpu_done`, `disp_valid` = 0.
  - `disp_data`, `cpu_rdata` = 8'h00.
  - RAM strobes 0.
- **CPU latency:**
  - Accept at cycle t; earliest issue is t+1; done is issue+1.
  - With `fetch_en`=1, `CPU_SLOTS`=8'h04 and the display requesting every slot, issue is ≤ t+8.
  - With `fetch_en`=0, issue is exactly t+1.
- **`line_start` during PEND:** the ring jumps; the CPU waits for the next eligible slot in the new alignment. An access already issued completes normally.
- **Simultaneous `cpu_req` and DONE:** the new request is accepted. Its earliest issue is the cycle after DONE.
- **`vram_we` and `vram_rd`** are never both 1.

## Structure
- Package `vdp_pkg` holds:
  - the slot width constant (8);
  - the default `CPU_SLOTS`;
  - the `VRAM_SIZE` default;
  - the CPU buffer state enumeration (IDLE/PEND/DONE).
- Sub-module `vdp_slot_ring`: the one-hot ring counter with `line_start` realign. It is instantiated once; the arbitration and CPU buffer logic stay in the top module.

## Test plan
- **Reset and ring:** reset, release, count 9 cycles → `slot` sequence 01,02,04,…,80,01. Pulse `line_start` when `slot`=8'h10 → next `slot`=8'h01.
- **Display read:** `fetch_en`=1, `disp_rd`=1, `disp_addr`=0x0801 in slot 8'h02, RAM returns 0x81 → `vram_rd`=1 at 0x0801 in that cycle; next cycle `disp_valid`=1, `disp_data`=0x81. The same request in slot 8'h04 → no `vram_rd`.
- **CPU write in reserved slot:** `fetch_en`=1, `disp_rd`=1 always. CPU write 0x5A→0x0C00 accepted at slot 8'h08 → `vram_we`=1 with `vram_din`=0x5A in slot 8'h04 seven cycles later; `cpu_done` the following cycle; `cpu_busy` high in between.
- **CPU read in blanking:** `fetch_en`=0, CPU read 0x0123, RAM holds 0xC3 → issue at t+1, `cpu_done`=1 and `cpu_rdata`=0xC3 at t+2.
- **Back-to-back and unused slot:** assert `cpu_req` again during DONE → accepted with no gap. With `fetch_en`=1 and `disp_rd`=0 in slot 8'h01 → the CPU issues in slot 8'h01.
- **Reset mid-access:** assert `reset` during PEND → `cpu_busy`=0 immediately and no `cpu_done`, `vram_we` or `vram_rd` afterwards.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP VRAM slot scheduler.
package vdp_pkg;
  localparam int SLOT_W = 8;
  localparam logic [SLOT_W-1:0] CPU_SLOTS_DEF = 8'h04;
  localparam int VRAM_SIZE_DEF = 8192;

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_PEND,
    CPU_DONE
  } cpu_state_e;
endpackage

// File: rtl/vdp_slot_ring.sv
// One-hot 8-slot ring, rotating every pxclk; line_start realigns to slot 0.
module vdp_slot_ring
  import vdp_pkg::*;
(
  input  logic              pxclk,
  input  logic              reset,
  input  logic              line_start,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = {slot_q[SLOT_W-2:0], slot_q[SLOT_W-1]};
    if (line_start) begin
      slot_d = {{(SLOT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      slot_q <= {{(SLOT_W-1){1'b0}}, 1'b1};
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/vdp_vram_sched.sv
// VRAM slot scheduler: grants each pxclk slot to the display fetch or one buffered CPU access.
module vdp_vram_sched
  import vdp_pkg::*;
#(
  parameter int                VRAM_SIZE = VRAM_SIZE_DEF,
  parameter logic [SLOT_W-1:0] CPU_SLOTS = CPU_SLOTS_DEF,
  localparam int               AW        = $clog2(VRAM_SIZE)
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              fetch_en,
  input  logic              disp_rd,
  input  logic [AW-1:0]     disp_addr,
  output logic [SLOT_W-1:0] slot,
  output logic [7:0]        disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [7:0]        cpu_rdata,
  output logic [AW-1:0]     vram_addr,
  output logic              vram_rd,
  output logic              vram_we,
  output logic [7:0]        vram_din,
  input  logic [7:0]        vram_dout
);

  cpu_state_e    state_q, state_d;
  logic          disp_own;
  logic          cpu_issue;
  logic          load_buf;
  logic          buf_we_q;
  logic [AW-1:0] buf_addr_q;
  logic [7:0]    buf_wdata_q;
  logic          disp_valid_q;
  logic [7:0]    disp_data_q;
  logic [7:0]    cpu_rdata_q;

  vdp_slot_ring u_ring (
    .pxclk      (pxclk),
    .reset      (reset),
    .line_start (line_start),
    .slot       (slot)
  );

  // Display wins any non-reserved slot it asks for; the CPU only fills what is left.
  assign disp_own  = fetch_en & disp_rd & ~(|(slot & CPU_SLOTS));
  assign cpu_issue = (state_q == CPU_PEND) & ~disp_own;
  assign cpu_busy  = (state_q == CPU_PEND);
  assign cpu_done  = (state_q == CPU_DONE);
  assign load_buf  = cpu_req & ~cpu_busy;

  always_comb begin
    vram_addr = '0;
    vram_rd   = 1'b0;
    vram_we   = 1'b0;
    vram_din  = 8'h00;
    if (disp_own) begin
      vram_addr = disp_addr;
      vram_rd   = 1'b1;
    end else if (cpu_issue) begin
      vram_addr = buf_addr_q;
      vram_rd   = ~buf_we_q;
      vram_we   = buf_we_q;
      vram_din  = buf_wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_IDLE: if (cpu_req) state_d = CPU_PEND;
      CPU_PEND: if (cpu_issue) state_d = CPU_DONE;
      CPU_DONE: state_d = cpu_req ? CPU_PEND : CPU_IDLE;
      default:  state_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      state_q <= CPU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The buffer is only consulted in PEND/DONE, so it needs no reset.
  always_ff @(posedge pxclk) begin
    if (load_buf) begin
      buf_we_q    <= cpu_we;
      buf_addr_q  <= cpu_addr;
      buf_wdata_q <= cpu_wdata;
    end
  end

  // RAM data arrives one cycle after the read; pass it through then and hold it afterwards.
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_valid_q ? vram_dout : disp_data_q;
  assign cpu_rdata  = (cpu_done && !buf_we_q) ? vram_dout : cpu_rdata_q;

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      cpu_rdata_q  <= 8'h00;
    end else begin
      disp_valid_q <= disp_own;
      disp_data_q  <= disp_data;
      cpu_rdata_q  <= cpu_rdata;
    end
  end

endmodule

// File: tb/tb_vdp_vram_sched.sv
// Directed bench for vdp_vram_sched with a behavioural single-port VRAM.
module tb_vdp_vram_sched;
  localparam int AW = 13;

  logic          pxclk = 1'b0;
  logic          reset;
  logic          line_start, fetch_en, disp_rd;
  logic [AW-1:0] disp_addr;
  logic [7:0]    slot;
  logic [7:0]    disp_data;
  logic          disp_valid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_busy, cpu_done;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] vram_addr;
  logic          vram_rd, vram_we;
  logic [7:0]    vram_din;
  logic [7:0]    vram_dout = 8'h00;

  logic [7:0] mem [0:8191];

  int checks = 0;
  int failures = 0;

  vdp_vram_sched dut (
    .pxclk(pxclk), .reset(reset), .line_start(line_start), .fetch_en(fetch_en),
    .disp_rd(disp_rd), .disp_addr(disp_addr), .slot(slot), .disp_data(disp_data),
    .disp_valid(disp_valid), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_we(vram_we), .vram_din(vram_din),
    .vram_dout(vram_dout)
  );

  always #5 pxclk = ~pxclk;

  always @(posedge pxclk) begin
    if (vram_we) mem[vram_addr] <= vram_din;
    if (vram_rd) vram_dout <= mem[vram_addr];
  end

  typedef struct {
    logic          ls, fe, dr;
    logic [AW-1:0] daddr;
    logic [7:0]    e_slot;
    logic          e_rd, e_we;
    logic [AW-1:0] e_addr;
    logic          e_dv;
    logic [7:0]    e_dd;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pxclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0801] = 8'h81;
    mem[13'h0123] = 8'hC3;

    //          ls  fe  dr  daddr     slot   rd  we  addr      dv  dd
    vecs[0]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h01,1'b0,1'b0,13'h0000,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b1,13'h0801, 8'h02,1'b1,1'b0,13'h0801,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b1,1'b1,13'h0801, 8'h04,1'b0,1'b0,13'h0000,1'b1,8'h81};
    vecs[3]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h08,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[4]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h10,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[5]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h20,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[6]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h40,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[7]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h80,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[8]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h01,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[9]  = '{1'b0,1'b0,1'b0,13'h0000, 8'h02,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[10] = '{1'b0,1'b0,1'b0,13'h0000, 8'h04,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[11] = '{1'b0,1'b0,1'b0,13'h0000, 8'h08,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[12] = '{1'b1,1'b0,1'b0,13'h0000, 8'h10,1'b0,1'b0,13'h0000,1'b0,8'h81};
    vecs[13] = '{1'b0,1'b0,1'b0,13'h0000, 8'h01,1'b0,1'b0,13'h0000,1'b0,8'h81};

    reset = 1'b1; line_start = 1'b0; fetch_en = 1'b0; disp_rd = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    repeat (3) tick();
    check("rst_slot", slot, 8'h01);
    check("rst_ctrl", {cpu_busy, cpu_done, disp_valid, vram_rd, vram_we}, 5'b0);
    check("rst_data", {disp_data, cpu_rdata}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      line_start = vecs[i].ls; fetch_en = vecs[i].fe; disp_rd = vecs[i].dr;
      disp_addr = vecs[i].daddr;
      settle();
      check($sformatf("vec%0d_slot", i), slot, vecs[i].e_slot);
      check($sformatf("vec%0d_strobe", i), {vram_rd, vram_we}, {vecs[i].e_rd, vecs[i].e_we});
      check($sformatf("vec%0d_addr", i), vram_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_disp", i), {disp_valid, disp_data}, {vecs[i].e_dv, vecs[i].e_dd});
    end

    // CPU write accepted at slot 08 lands in reserved slot 04 seven cycles later.
    tick(); line_start = 1'b0; fetch_en = 1'b1; disp_rd = 1'b1; disp_addr = 13'h0100;
    tick(); tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0C00; cpu_wdata = 8'h5A;
    settle();
    check("wr_accept_slot", slot, 8'h08);
    check("wr_accept_busy", cpu_busy, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(); cpu_req = 1'b0; settle();
      check($sformatf("wr_wait%0d", k), {cpu_busy, cpu_done, vram_rd, vram_we}, 4'b1010);
    end
    tick(); settle();
    check("wr_issue_slot", slot, 8'h04);
    check("wr_issue_strobe", {cpu_busy, vram_rd, vram_we}, 3'b101);
    check("wr_issue_port", {vram_addr, vram_din}, {13'h0C00, 8'h5A});
    tick(); settle();
    check("wr_done", {cpu_done, cpu_busy}, 2'b10);
    check("wr_mem", mem[13'h0C00], 8'h5A);

    // Blanking read: issue at t+1, done with data at t+2, then a back-to-back write.
    tick(); fetch_en = 1'b0; disp_rd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; settle();
    check("rd_accept", {cpu_busy, vram_rd, vram_we}, 3'b000);
    tick(); cpu_req = 1'b0; settle();
    check("rd_issue", {cpu_busy, vram_rd, vram_we, vram_addr}, {3'b110, 13'h0123});
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h3C; settle();
    check("rd_done", {cpu_done, cpu_busy, cpu_rdata}, {2'b10, 8'hC3});
    tick(); cpu_req = 1'b0; settle();
    check("b2b_issue", {cpu_busy, vram_we, vram_rd, vram_addr, vram_din},
          {3'b110, 13'h0200, 8'h3C});
    tick(); settle();
    check("b2b_done", {cpu_done, cpu_rdata}, {1'b1, 8'hC3});

    // Unused display slot: realign, accept, then leave slot 01 idle for the CPU.
    tick(); line_start = 1'b1; fetch_en = 1'b1; disp_rd = 1'b1; disp_addr = 13'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_wdata = 8'h77; settle();
    check("ls_disp_owns", {vram_rd, vram_we, vram_addr}, {2'b10, 13'h0100});
    tick(); line_start = 1'b0; disp_rd = 1'b0; cpu_req = 1'b0; settle();
    check("unused_slot", slot, 8'h01);
    check("unused_issue", {vram_we, vram_rd, vram_addr, vram_din}, {2'b10, 13'h0300, 8'h77});
    tick(); disp_rd = 1'b1; settle();
    check("unused_done", {cpu_done, slot}, {1'b1, 8'h02});

    // Reset while an access is pending discards it.
    tick(); tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_wdata = 8'h99; settle();
    check("rm_accept_slot", slot, 8'h08);
    tick(); cpu_req = 1'b0; settle();
    check("rm_pend", {cpu_busy, vram_we}, 2'b10);
    #1; reset = 1'b1; fetch_en = 1'b0; disp_rd = 1'b0; #1;
    check("rm_busy_drop", {cpu_busy, cpu_done, vram_rd, vram_we}, 4'b0000);
    check("rm_slot", slot, 8'h01);
    tick(); reset = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
        settle();
        if (cpu_done || vram_we || vram_rd || cpu_busy) bad++;
        tick();
      end
      check("rm_quiet", bad, 0);
    end
    check("rm_mem", mem[13'h0400], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
